// File: rtl/div_if.sv
// Request/response handshake bundle between the EX stage and the iterative divider.
interface div_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       div_op;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] div_result;
  logic             div_zero;

  modport master (
    output in_valid, div_op, div_src1, div_src2, out_ready,
    input  in_ready, out_valid, div_result, div_zero
  );

  modport slave (
    input  in_valid, div_op, div_src1, div_src2, out_ready,
    output in_ready, out_valid, div_result, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// One quotient bit per cycle; sign correction applied when the last step retires.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic  clk,
  input logic  resetn,
  input logic  flush,
  div_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sgn_q, sgn_r, rem_sel;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] result;
  logic             zero, out_vld;

  // Operation decode; div_op==0 falls through to div.wu.
  logic             is_signed, rsel;
  logic [WIDTH-1:0] src1_mag, src2_mag;

  always_comb begin
    is_signed = io.div_op[0] | io.div_op[1];
    rsel      = io.div_op[1] | io.div_op[3];
    src1_mag  = (is_signed && io.div_src1[WIDTH-1]) ? -io.div_src1 : io.div_src1;
    src2_mag  = (is_signed && io.div_src2[WIDTH-1]) ? -io.div_src2 : io.div_src2;
  end

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  logic [WIDTH:0]   r_sh, diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nx, quo_nx, res_nx;

  always_comb begin
    r_sh      = {rem, quo[WIDTH-1]};
    diff      = r_sh - {1'b0, dvs};
    no_borrow = ~diff[WIDTH];
    rem_nx    = no_borrow ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    quo_nx    = {quo[WIDTH-2:0], no_borrow};
    res_nx    = rem_sel ? (sgn_r ? -rem_nx : rem_nx)
                        : (sgn_q ? -quo_nx : quo_nx);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      sgn_q   <= 1'b0;
      sgn_r   <= 1'b0;
      rem_sel <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      out_vld <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          sgn_q   <= is_signed & (io.div_src1[WIDTH-1] ^ io.div_src2[WIDTH-1]);
          sgn_r   <= is_signed & io.div_src1[WIDTH-1];
          rem_sel <= rsel;
          quo     <= src1_mag;
          dvs     <= src2_mag;
          rem     <= '0;
          cnt     <= '0;
          if (io.div_src2 == '0) begin
            // Divide-by-zero skips iteration and sign correction entirely.
            state   <= DONE;
            zero    <= 1'b1;
            result  <= rsel ? io.div_src1 : '1;
            out_vld <= 1'b1;
          end else begin
            state <= BUSY;
            zero  <= 1'b0;
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= DONE;
            result  <= res_nx;
            out_vld <= 1'b1;
          end
        end
        DONE: if (io.out_ready) begin
          state   <= IDLE;
          out_vld <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready   = (state == IDLE);
  assign io.out_valid  = out_vld;
  assign io.div_result = result;
  assign io.div_zero   = zero;
endmodule
